// File: rtl/gcd_multilane_coprocessor.sv
// Multi-lane subtractive-Euclid GCD coprocessor. Round-robin dispatch and
// round-robin collection keep results in acceptance order.

module gcd_lane #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         take,
    input  logic [W-1:0] a_in,
    input  logic [W-1:0] b_in,
    output logic         idle,
    output logic         done,
    output logic [W-1:0] a
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t       state, state_next;
    logic [W-1:0] a_reg, b_reg, a_next, b_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            a_reg <= '0;
            b_reg <= '0;
        end else begin
            state <= state_next;
            a_reg <= a_next;
            b_reg <= b_next;
        end
    end

    always_comb begin
        state_next = state;
        a_next     = a_reg;
        b_next     = b_reg;
        case (state)
            IDLE: if (load) begin
                a_next     = a_in;
                b_next     = b_in;
                state_next = CALC;
            end
            CALC: begin
                if (b_reg == '0) begin
                    state_next = DONE;
                end else if (a_reg < b_reg) begin
                    a_next = b_reg;
                    b_next = a_reg;
                end else begin
                    a_next = a_reg - b_reg;
                end
            end
            DONE: if (take) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign idle = (state == IDLE);
    assign done = (state == DONE);
    assign a    = a_reg;
endmodule

module gcd_multilane_coprocessor #(
    parameter int W     = 16,
    parameter int LANES = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       operands_val,
    input  logic [W-1:0]               operands_bits_A,
    input  logic [W-1:0]               operands_bits_B,
    output logic                       operands_rdy,
    output logic                       result_val,
    output logic [W-1:0]               result_bits,
    input  logic                       result_rdy,
    output logic [$clog2(LANES+1)-1:0] in_flight
);
    localparam int PW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int CW = $clog2(LANES + 1);

    logic [PW-1:0]             disp_ptr, coll_ptr;
    logic [LANES-1:0]          lane_idle, lane_done, lane_load, lane_take;
    logic [LANES-1:0][W-1:0]   lane_a;
    logic                      accept, take;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(LANES - 1)) ? '0 : p + PW'(1);
    endfunction

    // Handshake outputs depend only on lane state, never on val/rdy inputs.
    assign operands_rdy = lane_idle[disp_ptr];
    assign result_val   = lane_done[coll_ptr];
    assign result_bits  = result_val ? lane_a[coll_ptr] : '0;
    assign accept       = operands_val && operands_rdy;
    assign take         = result_val && result_rdy;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign lane_load[l] = accept && (disp_ptr == PW'(l));
        assign lane_take[l] = take && (coll_ptr == PW'(l));

        gcd_lane #(.W(W)) u_lane (
            .clk   (clk),
            .reset (reset),
            .load  (lane_load[l]),
            .take  (lane_take[l]),
            .a_in  (operands_bits_A),
            .b_in  (operands_bits_B),
            .idle  (lane_idle[l]),
            .done  (lane_done[l]),
            .a     (lane_a[l])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            disp_ptr  <= '0;
            coll_ptr  <= '0;
            in_flight <= '0;
        end else begin
            if (accept) disp_ptr <= wrap_inc(disp_ptr);
            if (take)   coll_ptr <= wrap_inc(coll_ptr);
            if (accept && !take)      in_flight <= in_flight + CW'(1);
            else if (take && !accept) in_flight <= in_flight - CW'(1);
        end
    end
endmodule

// File: tb/tb_gcd_multilane_coprocessor.sv
// Bench for gcd_multilane_coprocessor: directed cases plus randomized traffic
// on several lane counts against an in-order GCD queue model.

module tb_gcd_multilane_coprocessor;
    localparam int NRND      = 3300;
    localparam int CYC_LIMIT = 80000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit rnd_done [3];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int model_gcd(input int x, input int y);
        int t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    function automatic int pick();
        if ($urandom_range(0, 7) == 0) return 0;
        return int'($urandom_range(1, 63));
    endfunction

    // Directed DUT: W=16, LANES=4
    logic        d_reset, d_val, d_rdy, d_rv, d_rr;
    logic [15:0] d_a, d_b, d_bits;
    logic [2:0]  d_inf;

    gcd_multilane_coprocessor #(.W(16), .LANES(4)) dut_d (
        .clk(clk), .reset(d_reset), .operands_val(d_val), .operands_bits_A(d_a),
        .operands_bits_B(d_b), .operands_rdy(d_rdy), .result_val(d_rv),
        .result_bits(d_bits), .result_rdy(d_rr), .in_flight(d_inf)
    );

    // Wide DUT: W=32, LANES=4
    logic        w_reset, w_val, w_rdy, w_rv, w_rr;
    logic [31:0] w_a, w_b, w_bits;
    logic [2:0]  w_inf;

    gcd_multilane_coprocessor #(.W(32), .LANES(4)) dut_w (
        .clk(clk), .reset(w_reset), .operands_val(w_val), .operands_bits_A(w_a),
        .operands_bits_B(w_b), .operands_rdy(w_rdy), .result_val(w_rv),
        .result_bits(w_bits), .result_rdy(w_rr), .in_flight(w_inf)
    );

    task automatic run_one(input logic [15:0] a, input logic [15:0] b,
                           input int exp, input int lat);
        int edges;
        @(negedge clk);
        d_val = 1'b1; d_a = a; d_b = b; d_rr = 1'b1;
        check("rdy before accept", d_rdy, 1);
        @(negedge clk);
        d_val = 1'b0;
        edges = 1;
        check("in_flight after accept", d_inf, 1);
        while (!d_rv && edges < 100) begin
            @(negedge clk);
            edges++;
        end
        check("latency", edges, lat);
        check("single result", d_bits, exp);
        @(negedge clk);
        check("in_flight after take", d_inf, 0);
        check("result_val after take", d_rv, 0);
    endtask

    // Randomized traffic on LANES = 4, 3, 1
    for (genvar g = 0; g < 3; g++) begin : g_rnd
        localparam int L   = (g == 0) ? 4 : (g == 1) ? 3 : 1;
        localparam int CWR = $clog2(L + 1);

        logic           r_reset, val, rdy, rv, rr;
        logic [15:0]    a, b, bits;
        logic [CWR-1:0] inf;

        gcd_multilane_coprocessor #(.W(16), .LANES(L)) dut (
            .clk(clk), .reset(r_reset), .operands_val(val), .operands_bits_A(a),
            .operands_bits_B(b), .operands_rdy(rdy), .result_val(rv),
            .result_bits(bits), .result_rdy(rr), .in_flight(inf)
        );

        initial begin
            int q[$];
            int sent;
            int cyc;
            r_reset = 1'b1; val = 1'b0; a = '0; b = '0; rr = 1'b0;
            sent = 0; cyc = 0;
            repeat (2) @(negedge clk);
            r_reset = 1'b0;
            while ((sent < NRND || q.size() > 0) && cyc < CYC_LIMIT) begin
                @(negedge clk);
                cyc++;
                check($sformatf("L%0d in_flight", L), inf, q.size());
                check($sformatf("L%0d in_flight bound", L), inf <= L, 1);
                check($sformatf("L%0d operands_rdy", L), rdy, q.size() < L);
                if (rv) begin
                    if (q.size() == 0) check($sformatf("L%0d spurious result", L), rv, 0);
                    else               check($sformatf("L%0d result", L), bits, q[0]);
                end else begin
                    check($sformatf("L%0d idle result_bits", L), bits, 0);
                end
                rr = ($urandom_range(0, 3) != 0);
                if (sent < NRND && $urandom_range(0, 3) != 0) begin
                    val = 1'b1;
                    a = 16'(pick());
                    b = 16'(pick());
                end else begin
                    val = 1'b0;
                    a = 16'($urandom);
                    b = 16'($urandom);
                end
                if (rv && rr && q.size() > 0) void'(q.pop_front());
                if (val && rdy) begin
                    q.push_back(model_gcd(int'(a), int'(b)));
                    sent++;
                end
            end
            val = 1'b0;
            check($sformatf("L%0d pairs sent", L), sent, NRND);
            check($sformatf("L%0d results drained", L), q.size(), 0);
            rnd_done[g] = 1'b1;
        end
    end

    initial begin
        int ea [7] = '{12, 200, 15, 99, 1, 144, 0};
        int eb [7] = '{8, 35, 9, 36, 2, 168, 0};
        int er [7] = '{4, 5, 3, 9, 1, 24, 0};
        int pa [4] = '{12, 15, 99, 1};
        int pb [4] = '{8, 9, 36, 2};
        int pr [4] = '{4, 3, 9, 1};
        int idx, got, cyc, edges;
        bit saw_drop;

        check("model gcd(12,8)", model_gcd(12, 8), 4);
        check("model gcd(0,250)", model_gcd(0, 250), 250);
        check("model gcd(144,168)", model_gcd(144, 168), 24);
        check("model gcd(0,0)", model_gcd(0, 0), 0);

        d_reset = 1'b1; d_val = 1'b0; d_a = '0; d_b = '0; d_rr = 1'b0;
        w_reset = 1'b1; w_val = 1'b0; w_a = '0; w_b = '0; w_rr = 1'b0;
        repeat (2) @(negedge clk);
        check("reset operands_rdy", d_rdy, 1);
        check("reset result_val", d_rv, 0);
        check("reset result_bits", d_bits, 0);
        check("reset in_flight", d_inf, 0);
        d_reset = 1'b0;

        // single pair (7,7)
        run_one(16'd7, 16'd7, 7, 4);

        // back-to-back stream, results in order
        idx = 0; got = 0; cyc = 0; saw_drop = 1'b0; d_rr = 1'b1;
        while ((idx < 7 || got < 7) && cyc < 500) begin
            @(negedge clk);
            cyc++;
            if (d_rv) begin
                if (got < 7) check("b2b result", d_bits, er[got]);
                got++;
            end
            if (idx == 4 && !saw_drop) begin
                check("rdy drops after 4 accepts", d_rdy, 0);
                saw_drop = 1'b1;
            end
            if (idx < 7) begin
                d_val = 1'b1; d_a = 16'(ea[idx]); d_b = 16'(eb[idx]);
                if (d_rdy) idx++;
            end else begin
                d_val = 1'b0;
            end
        end
        d_val = 1'b0;
        check("b2b result count", got, 7);
        @(negedge clk);
        check("b2b in_flight drained", d_inf, 0);

        // backpressure: fill all lanes with result_rdy low
        d_rr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            d_val = 1'b1; d_a = 16'(pa[i]); d_b = 16'(pb[i]);
        end
        @(negedge clk);
        d_val = 1'b0;
        repeat (60) @(negedge clk);
        check("full operands_rdy", d_rdy, 0);
        check("full in_flight", d_inf, 4);
        check("full result_val", d_rv, 1);
        check("full result_bits", d_bits, 4);
        for (int i = 0; i < 5; i++) begin
            d_val = 1'b1; d_a = 16'(100 + i); d_b = 16'(3 + i);
            @(negedge clk);
            check("held result_bits", d_bits, 4);
            check("held in_flight", d_inf, 4);
        end
        d_val = 1'b0;
        d_rr = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain result_val", d_rv, 1);
            check("drain result", d_bits, pr[i]);
            @(negedge clk);
        end
        check("drain in_flight", d_inf, 0);
        check("drain result_val low", d_rv, 0);

        // zero operands
        run_one(16'd0, 16'd250, 250, 3);
        run_one(16'd5, 16'd0, 5, 2);
        run_one(16'd0, 16'd0, 0, 2);

        // W=32 reset mid-computation
        w_reset = 1'b0;
        @(negedge clk);
        w_val = 1'b1; w_a = 32'hFFFF_0000; w_b = 32'h0000_FFFF; w_rr = 1'b1;
        @(negedge clk);
        w_val = 1'b0;
        repeat (20) @(negedge clk);
        check("w32 mid-calc result_val", w_rv, 0);
        check("w32 mid-calc in_flight", w_inf, 1);
        w_reset = 1'b1;
        @(negedge clk);
        w_reset = 1'b0;
        check("w32 post-reset result_val", w_rv, 0);
        check("w32 post-reset in_flight", w_inf, 0);
        check("w32 post-reset operands_rdy", w_rdy, 1);
        w_val = 1'b1; w_a = 32'd27; w_b = 32'd15;
        @(negedge clk);
        w_val = 1'b0;
        edges = 1;
        while (!w_rv && edges < 100) begin
            @(negedge clk);
            edges++;
        end
        check("w32 (27,15) latency", edges, 11);
        check("w32 (27,15) result", w_bits, 3);
        @(negedge clk);
        check("w32 final in_flight", w_inf, 0);

        while (!(rnd_done[0] && rnd_done[1] && rnd_done[2])) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
